// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the nibble-serial adder:
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - SLICE_W   : width of one slice processed per clock (4 bits)
//   - idx_width : width of the slice index counter for a given operand width
//                 (clog2 of the slice count, never less than 1)
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int width);
        int nib;
        nib = width / SLICE_W;
        // A single-slice adder still needs a 1-bit index register.
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// -----------------------------------------------------------------------------
// ripple_adder
// 4-bit combinational ripple-carry adder built from a chain of full adders.
// Ports:
//   a, b  [3:0] in   addends
//   cin         in   carry into bit 0
//   sum   [3:0] out  a + b + cin (low 4 bits)
//   cout        out  carry out of bit 3
// -----------------------------------------------------------------------------
module ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// WIDTH-bit adder that pushes one 4-bit slice per clock through a single
// ripple_adder, registering the carry between slices. Valid/ready handshake on
// both the operand side and the result side; one operation in flight at a time.
//
// Parameters:
//   WIDTH      operand/result width, a multiple of 4 and >= 4 (default 16)
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   a/b/cin hold a valid operand set
//   in_ready   out  adder idle and able to accept operands
//   a, b       in   operands [WIDTH-1:0]
//   cin        in   carry into bit 0
//   out_valid  out  sum/cout (and ovf) hold a result
//   out_ready  in   consumer takes the result
//   sum        out  a + b + cin mod 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow; present only when SERIAL_ADD_OVF_EN is
//                   defined
//
// Latency: out_valid rises WIDTH/4 cycles after the accept edge.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / SLICE_W;
    localparam int IW  = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    state_t           state_reg;
    logic [IW-1:0]    idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Slice selection from the frozen operand registers.
    assign a_slice = a_reg[idx_reg*SLICE_W +: SLICE_W];
    assign b_slice = b_reg[idx_reg*SLICE_W +: SLICE_W];

    ripple_adder u_ripple_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_reg;
    logic carry_into_msb;

    // Only meaningful on the last slice, where slice_sum[3] is sum[WIDTH-1].
    assign carry_into_msb = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_sum[SLICE_W-1];
    assign ovf            = ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        carry_reg    <= cin;
                        idx_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                    end
                end

                RUN: begin
                    sum_reg[idx_reg*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_reg <= slice_cout;
                    if (idx_reg == LAST_IDX) begin
                        // idx holds at the last slice rather than wrapping.
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        cout_reg      <= slice_cout;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_reg       <= carry_into_msb ^ slice_cout;
`endif
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end

                DONE: begin
                    // Result held until taken; the next accept waits for IDLE.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Directed bench for nibble_serial_adder at WIDTH=16. Expected results are
// computed from the operands with a plain integer add and queued when the
// operands are accepted; they are popped and compared when out_valid appears.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // {ovf, cout, sum}
    logic [W+1:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    // Drive one operand set, wait for the accept edge, then scramble the inputs
    // so a non-frozen operand capture would show up in the result.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        sb.push_back(model(x, y, c));
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic compare_result(input string tag);
        logic [W+1:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sbempty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
            chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
            chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_post", 32'(in_ready), 32'd1);
        chk("out_valid_post", 32'(out_valid), 32'd0);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c);
        int n;
        start_op(x, y, c);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'd4);
        compare_result(tag);
        handshake();
    endtask

    initial begin
        int n;
        int c1;
        int seen;
        logic [W-1:0] held_sum;
        logic         held_cout;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        // Longest carry chain and carry-in without carry-out.
        full_op("maxcarry", 16'hFFFF, 16'h0001, 1'b0);
        full_op("cin", 16'h1234, 16'h4321, 1'b1);
        full_op("mix", 16'h8F0F, 16'h70F1, 1'b1);

        // Backpressure: result held for 3 cycles with out_ready low.
        start_op(16'hA5A5, 16'h5A5B, 1'b0);
        wait_valid(n);
        chk("bp_lat", 32'(n), 32'd4);
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum_stable", 32'(sum), 32'(held_sum));
            chk("bp_cout_stable", 32'(cout), 32'(held_cout));
        end
        compare_result("bp");
        handshake();

        // Back-to-back with in_valid held high: second set waits for IDLE.
        out_ready = 1'b1;
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
        chk("b2b_ready0", 32'(in_ready), 32'd1);
        sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
        tick();
        a = 16'h7777; b = 16'h8889; cin = 1'b1;
        sb.push_back(model(16'h7777, 16'h8889, 1'b1));
        wait_valid(n);
        chk("b2b_lat1", 32'(n), 32'd4);
        c1 = cyc;
        compare_result("b2b1");
        tick();
        chk("b2b_ready1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_busy", 32'(in_ready), 32'd0);
        wait_valid(n);
        chk("b2b_lat2", 32'(n), 32'd4);
        chk("b2b_gap", 32'(cyc - c1), 32'd6);
        compare_result("b2b2");
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 32'(in_ready), 32'd1);

        // Reset after two slices: operation abandoned, no stale result.
        start_op(16'h1111, 16'h2222, 1'b0);
        void'(sb.pop_back());
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrun_in_ready", 32'(in_ready), 32'd1);
        chk("rrun_out_valid", 32'(out_valid), 32'd0);
        chk("rrun_sum", 32'(sum), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rrun_no_stale", 32'(seen), 32'd0);

`ifdef SERIAL_ADD_OVF_EN
        full_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
        full_op("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0);
        full_op("ovf_neg", 16'h8000, 16'h8000, 1'b0);
`endif

        // A few random operations against the integer model.
        for (int i = 0; i < 6; i++) begin
            full_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
